// File: rtl/minv_mdiv_host.sv
// ============================================================================
// Module   : minv_mdiv_host
// Brief    : Initiator sequencer for the MINV_MDIV core: serialises a/p/b,
//            starts the core, waits for ready and drains the 256-bit result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module minv_mdiv_host #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int TIMEOUT   = 16384
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [WORD_W*NUM_WORDS-1:0] op_a,
    input  logic [WORD_W*NUM_WORDS-1:0] op_b,
    input  logic [WORD_W*NUM_WORDS-1:0] op_p,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [WORD_W*NUM_WORDS-1:0] result,
    output logic [WORD_W-1:0]           datain,
    output logic                        loada,
    output logic                        loadp,
    output logic                        loadb,
    output logic                        minv_mdiv,
    output logic                        minv_mdiv_en,
    output logic                        out_ready,
    input  logic                        minv_mdiv_rdy,
    input  logic [WORD_W-1:0]           result_out
);

    localparam int OP_W  = WORD_W * NUM_WORDS;
    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int SEL_W = $clog2(OP_W);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_A   = 3'd1;
    localparam logic [2:0] S_LOAD_P   = 3'd2;
    localparam logic [2:0] S_LOAD_B   = 3'd3;
    localparam logic [2:0] S_START    = 3'd4;
    localparam logic [2:0] S_WAIT_RDY = 3'd5;
    localparam logic [2:0] S_READ     = 3'd6;
    localparam logic [2:0] S_FIN      = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [OP_W-1:0]  a_q, b_q, p_q, result_q;
    logic             mode_q;

    logic             w_accept;
    logic             w_last;
    logic             w_to_hit;
    logic [SEL_W-1:0] w_sel;

    assign w_accept = (state_q == S_IDLE) && start;
    assign w_last   = (cnt_q == CNT_W'(NUM_WORDS - 1));
    assign w_to_hit = (tcnt_q == TO_W'(TIMEOUT - 1));
    assign w_sel    = SEL_W'(cnt_q) * SEL_W'(WORD_W);
    assign result   = result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            if (w_accept) begin
                a_q    <= op_a;
                b_q    <= op_b;
                p_q    <= op_p;
                mode_q <= mode;
            end
            // Capture slot is the word counter, so a stalled cycle writes nothing.
            if ((state_q == S_READ) && minv_mdiv_rdy) begin
                result_q[w_sel +: WORD_W] <= result_out;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
                end
            end
            S_LOAD_A: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (w_last) state_d = S_LOAD_P;
            end
            S_LOAD_P: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (w_last) state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (w_last) state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT_RDY;
                tcnt_d  = '0;
            end
            S_WAIT_RDY: begin
                if (minv_mdiv_rdy) begin
                    state_d = S_READ;
                end else if (w_to_hit) begin
                    state_d = S_IDLE;
                end else if (tcnt_q != TO_W'(TIMEOUT)) begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            S_READ: begin
                if (minv_mdiv_rdy) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (w_last) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        loada        = 1'b0;
        loadp        = 1'b0;
        loadb        = 1'b0;
        datain       = '0;
        minv_mdiv_en = 1'b0;
        out_ready    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                loada  = 1'b1;
                datain = a_q[w_sel +: WORD_W];
            end
            S_LOAD_P: begin
                loadp  = 1'b1;
                datain = p_q[w_sel +: WORD_W];
            end
            S_LOAD_B: begin
                loadb  = 1'b1;
                datain = b_q[w_sel +: WORD_W];
            end
            S_START:    minv_mdiv_en = 1'b1;
            S_WAIT_RDY: err = !minv_mdiv_rdy && w_to_hit;
            S_READ:     out_ready = 1'b1;
            S_FIN:      done = 1'b1;
            default:    ;
        endcase
        busy      = (state_q != S_IDLE) && (state_q != S_FIN) && !err;
        minv_mdiv = mode_q && (state_q != S_IDLE) && (state_q != S_FIN);
    end

endmodule

`default_nettype wire

// File: tb/tb_minv_mdiv_host.sv
// ============================================================================
// Module   : tb_minv_mdiv_host
// Brief    : Directed self-checking bench for minv_mdiv_host (main instance plus
//            a TIMEOUT=64 instance for the timeout path).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_minv_mdiv_host;

    localparam logic [255:0] C_A = 256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    localparam logic [255:0] C_B = 256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
    localparam logic [255:0] C_P = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] C_RES = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    localparam logic [255:0] C_TO_RES = {8{32'hCAFEF00D}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, start_to = 1'b0;
    logic         mode = 1'b0;
    logic [255:0] op_a = '0, op_b = '0, op_p = '0;
    logic         rdy = 1'b0, rdy_to = 1'b0;
    logic [31:0]  result_out;

    logic         busy, done, err, loada, loadp, loadb, minv_mdiv, minv_mdiv_en, out_ready;
    logic [255:0] result;
    logic [31:0]  datain;

    logic         to_busy, to_done, to_err, to_loada, to_loadp, to_loadb, to_minv, to_en, to_out_ready;
    logic [255:0] to_result;
    logic [31:0]  to_datain;

    int errors = 0;
    int checks = 0;
    int widx;

    always #5 clk = ~clk;

    minv_mdiv_host u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .op_a(op_a), .op_b(op_b), .op_p(op_p),
        .busy(busy), .done(done), .err(err), .result(result),
        .datain(datain), .loada(loada), .loadp(loadp), .loadb(loadb),
        .minv_mdiv(minv_mdiv), .minv_mdiv_en(minv_mdiv_en), .out_ready(out_ready),
        .minv_mdiv_rdy(rdy), .result_out(result_out)
    );

    minv_mdiv_host #(.TIMEOUT(64)) u_dut_to (
        .clk(clk), .rst(rst), .start(start_to), .mode(mode),
        .op_a(op_a), .op_b(op_b), .op_p(op_p),
        .busy(to_busy), .done(to_done), .err(to_err), .result(to_result),
        .datain(to_datain), .loada(to_loada), .loadp(to_loadp), .loadb(to_loadb),
        .minv_mdiv(to_minv), .minv_mdiv_en(to_en), .out_ready(to_out_ready),
        .minv_mdiv_rdy(rdy_to), .result_out(32'hCAFEF00D)
    );

    // Core model: returns 0x11111111 * (n+1) for the n-th word of each drain.
    always @(posedge clk or negedge rst) begin
        if (!rst) widx <= 0;
        else if (out_ready && rdy) widx <= widx + 1;
    end
    assign result_out = 32'h11111111 * 32'((widx % 8) + 1);

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic m, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] p, input int rdy_delay, input bit stall,
                          input int restart_at);
        int   nrdy = 0, ndone = 0, done_cyc = -1, caps = 0, stall_left = 0, w0;
        bit   stalled = 0;
        logic [31:0] d1 = '0, d2 = '0, d9 = '0, d17 = '0, exp_d;
        mode = m; op_a = a; op_b = b; op_p = p; start = 1'b1;
        w0 = widx;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = ~a; op_b = ~b; op_p = ~p; mode = ~m;
        for (int c = 1; c <= 400; c++) begin
            start = (c == restart_at);
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = (c >= 25 + rdy_delay);
            end
            #1;
            exp_d = (c >= 1  && c <= 8)  ? a[(c-1)*32 +: 32] :
                    (c >= 9  && c <= 16) ? p[(c-9)*32 +: 32] :
                    (c >= 17 && c <= 24) ? b[(c-17)*32 +: 32] : 32'h0;
            if (c == 1)  d1  = datain;
            if (c == 2)  d2  = datain;
            if (c == 9)  d9  = datain;
            if (c == 17) d17 = datain;
            chk("loada", loada, c >= 1 && c <= 8);
            chk("loadp", loadp, c >= 9 && c <= 16);
            chk("loadb", loadb, c >= 17 && c <= 24);
            chk("datain", datain, exp_d);
            chk("en", minv_mdiv_en, c == 25);
            if (out_ready) nrdy++;
            if (out_ready && rdy) caps++;
            if (stall && !stalled && caps == 4) begin
                stall_left = 3;
                stalled = 1;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
                chk("busy_at_done", busy, 1'b0);
                chk("result", result, C_RES);
                break;
            end
            chk("busy", busy, 1'b1);
            chk("minv_mdiv", minv_mdiv, m);
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        chk("datain_c1", d1, 32'h334C74C7);
        chk("datain_c2", d2, 32'h715A4589);
        chk("datain_c9", d9, 32'hFFFFFFFF);
        chk("datain_c17", d17, 32'h2139F0A0);
        chk("done_count", ndone, 1);
        chk("done_cycle", done_cyc, 25 + rdy_delay + 9 + (stall ? 3 : 0));
        chk("out_ready_cycles", nrdy, stall ? 11 : 8);
        @(posedge clk); #2;
        chk("captures", widx - w0, 8);
        chk("done_pulse", done, 1'b0);
        chk("result_hold", result, C_RES);
    endtask

    initial begin
        int nerr, err_cyc, bad;
        // Reset state
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {loada, loadp, loadb, minv_mdiv_en, out_ready, done, err, minv_mdiv}, 8'h00);
        chk("rst_datain", datain, 32'h0);
        chk("rst_result", result, 256'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // SM2 division with drain 100 cycles after en
        run_op(1'b0, C_A, C_B, C_P, 100, 1'b0, 0);
        // Stalled drain
        run_op(1'b0, C_A, C_B, C_P, 100, 1'b1, 0);
        // Inversion mode, with an ignored start while busy
        run_op(1'b1, C_A, C_B, C_P, 10, 1'b0, 5);

        // Reset during LOAD_P, then a fresh run restarts at word 0
        op_a = C_A; op_b = C_B; op_p = C_P; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 12; c++) begin
            @(posedge clk); #1;
        end
        #1;
        chk("pre_rst_loadp", loadp, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst_strobes", {loada, loadp, loadb, minv_mdiv_en, busy, minv_mdiv}, 6'h00);
        chk("mid_rst_datain", datain, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, C_A, C_B, C_P, 3, 1'b0, 0);

        // Preload the timeout instance's result with a successful run
        rdy_to = 1'b1; start_to = 1'b1;
        @(posedge clk); #1;
        start_to = 1'b0;
        for (int c = 1; c < 45; c++) begin
            @(posedge clk); #1;
        end
        rdy_to = 1'b0;
        chk("to_preload_result", to_result, C_TO_RES);

        // Timeout: rdy never rises
        nerr = 0; err_cyc = -1; bad = 0;
        start_to = 1'b1;
        @(posedge clk); #1;
        start_to = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            #1;
            if (to_err) begin
                nerr++;
                err_cyc = c;
            end
            if (to_out_ready || to_done) bad++;
            if (c == 88) chk("to_busy_before_err", to_busy, 1'b1);
            if (c == 89) chk("to_busy_at_err", to_busy, 1'b0);
            @(posedge clk); #1;
        end
        chk("to_err_count", nerr, 1);
        chk("to_err_cycle", err_cyc, 89);
        chk("to_no_ready_done", bad, 0);
        chk("to_result_kept", to_result, C_TO_RES);
        chk("to_idle_after", to_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
